// File: rtl/txpippm_pkg.sv
// Shared definitions for the TX phase-interpolator step scheduler.
package txpippm_pkg;

  // Sequencer states; encodings are visible on the debug state port.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HIGH = 2'b01,
    ST_LOW  = 2'b11,
    ST_DONE = 2'b10
  } state_t;

  // Number of cycles each pulse stays high.
  localparam int PULSE_HIGH_CYCLES = 4;

  // Shortest rising-edge-to-rising-edge spacing.
  // This guarantees at least four low cycles between pulses.
  localparam int MIN_INTERVAL = 8;

  // Position of the direction bit in the 5-bit PI step size.
  // Bits below it hold the magnitude.
  localparam int STEPSIZE_DIR_BIT = 4;

endpackage : txpippm_pkg

// File: rtl/txpippm_interval_timer.sv
// Loadable up-counter that times the high and low phases of each pulse.
// It also provides the terminal compares the sequencer needs.
module txpippm_interval_timer
  import txpippm_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             gtwiz_userclk_tx_usrclk_in,
  input  logic             reset_in,
  input  logic             clear_in,
  input  logic             enable_in,
  input  logic [WIDTH-1:0] interval_in,
  output logic             ge_high_end_out,
  output logic             ge_abort_end_out,
  output logic             at_terminal_out
);

  logic [WIDTH-1:0] count_q;

  // Count up while enabled.
  // A clear restarts the count at zero for the next pulse.
  always_ff @(posedge gtwiz_userclk_tx_usrclk_in) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset_in || clear_in) begin
      count_q <= '0;
    end else if (enable_in) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  // Terminal compares used by the sequencer.
  always_comb begin
    ge_high_end_out  = (count_q >= WIDTH'(PULSE_HIGH_CYCLES - 1));
    ge_abort_end_out = (count_q >= WIDTH'(MIN_INTERVAL - 1));
    at_terminal_out  = (count_q == interval_in - WIDTH'(1));
  end

endmodule : txpippm_interval_timer

// File: rtl/txpippm_step_scheduler.sv
// Command-driven sequencer.
// It emits N well-formed step pulses to the TX PI PPM controllers.
module txpippm_step_scheduler
  import txpippm_pkg::*;
#(
  parameter int CHANNEL_COUNT  = 10,
  parameter int COUNT_WIDTH    = 16,
  parameter int INTERVAL_WIDTH = 16
) (
  input  logic                      gtwiz_userclk_tx_usrclk_in,
  input  logic                      reset_in,
  input  logic                      cmd_valid_in,
  output logic                      cmd_ready_out,
  input  logic [CHANNEL_COUNT-1:0]  cmd_sel_in,
  input  logic [COUNT_WIDTH-1:0]    cmd_count_in,
  input  logic [4:0]                cmd_stepsize_in,
  input  logic [INTERVAL_WIDTH-1:0] cmd_interval_in,
  input  logic                      abort_in,
  output logic [CHANNEL_COUNT-1:0]  sel_out,
  output logic                      pulse_out,
  output logic [4:0]                stepsize_out,
  output logic                      busy_out,
  output logic                      done_out,
  output logic                      aborted_out,
  output logic [COUNT_WIDTH-1:0]    pulses_issued_out,
  output logic [1:0]                state_out
);

  state_t                    state_q, state_d;
  logic [CHANNEL_COUNT-1:0]  sel_q;
  logic [4:0]                stepsize_q;
  logic [COUNT_WIDTH-1:0]    count_q;
  logic [COUNT_WIDTH-1:0]    issued_q;
  logic [INTERVAL_WIDTH-1:0] interval_q;
  logic                      abort_flag_q;
  logic                      ended_by_abort_q;

  logic accept;
  logic timer_clear;
  logic timer_enable;
  logic end_by_abort;
  logic ge_high_end;
  logic ge_abort_end;
  logic at_terminal;

  assign cmd_ready_out = (state_q == ST_IDLE) && !reset_in;
  assign accept        = cmd_valid_in && cmd_ready_out;
  assign timer_enable  = (state_q == ST_HIGH) || (state_q == ST_LOW);

  txpippm_interval_timer #(
    .WIDTH (INTERVAL_WIDTH)
  ) u_timer (
    .gtwiz_userclk_tx_usrclk_in (gtwiz_userclk_tx_usrclk_in),
    .reset_in                   (reset_in),
    .clear_in                   (timer_clear),
    .enable_in                  (timer_enable),
    .interval_in                (interval_q),
    .ge_high_end_out            (ge_high_end),
    .ge_abort_end_out           (ge_abort_end),
    .at_terminal_out            (at_terminal)
  );

  // State register.
  always_ff @(posedge gtwiz_userclk_tx_usrclk_in) begin
    if (reset_in) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  // In the low phase, the abort exit is checked before the natural end.
  always_comb begin
    // NOTE: every always_comb output gets a default first.
    // Without it, a path that skips an assignment would infer a latch.
    state_d      = state_q;
    timer_clear  = 1'b0;
    end_by_abort = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d     = (cmd_count_in == '0) ? ST_DONE : ST_HIGH;
          timer_clear = 1'b1;
        end
      end
      ST_HIGH: begin
        if (ge_high_end) begin
          state_d = ST_LOW;
        end
      end
      ST_LOW: begin
        if (abort_flag_q && ge_abort_end) begin
          state_d      = ST_DONE;
          end_by_abort = 1'b1;
        end else if (at_terminal) begin
          if (issued_q == count_q) begin
            state_d = ST_DONE;
          end else begin
            state_d     = ST_HIGH;
            timer_clear = 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Command latch, issued counter and abort bookkeeping.
  always_ff @(posedge gtwiz_userclk_tx_usrclk_in) begin
    if (reset_in) begin
      sel_q            <= '0;
      stepsize_q       <= '0;
      count_q          <= '0;
      issued_q         <= '0;
      interval_q       <= '0;
      abort_flag_q     <= 1'b0;
      ended_by_abort_q <= 1'b0;
    end else begin
      if (accept) begin
        // A zero-length command steps no channel.
        // Its select is therefore never presented downstream.
        sel_q            <= (cmd_count_in == '0) ? '0 : cmd_sel_in;
        stepsize_q       <= cmd_stepsize_in;
        count_q          <= cmd_count_in;
        interval_q       <= (cmd_interval_in < INTERVAL_WIDTH'(MIN_INTERVAL))
                            ? INTERVAL_WIDTH'(MIN_INTERVAL) : cmd_interval_in;
        issued_q         <= '0;
        abort_flag_q     <= 1'b0;
        ended_by_abort_q <= 1'b0;
      end
      if (state_q == ST_HIGH && ge_high_end) begin
        issued_q <= issued_q + COUNT_WIDTH'(1);
      end
      if (timer_enable && abort_in) begin
        abort_flag_q <= 1'b1;
      end
      if (end_by_abort) begin
        ended_by_abort_q <= 1'b1;
      end
    end
  end

  // Output decode from registered state and registered command fields.
  always_comb begin
    pulse_out         = (state_q == ST_HIGH);
    busy_out          = timer_enable;
    done_out          = (state_q == ST_DONE);
    aborted_out       = (state_q == ST_DONE) && ended_by_abort_q;
    sel_out           = (state_q == ST_IDLE) ? '0 : sel_q;
    stepsize_out      = stepsize_q;
    pulses_issued_out = issued_q;
    state_out         = state_q;
  end

endmodule : txpippm_step_scheduler

// File: tb/tb_txpippm_step_scheduler.sv
// Directed bench for txpippm_step_scheduler.
module tb_txpippm_step_scheduler;

  logic        gtwiz_userclk_tx_usrclk_in = 1'b0;
  logic        reset_in = 1'b1;
  logic        cmd_valid_in = 1'b0;
  logic        cmd_ready_out;
  logic [9:0]  cmd_sel_in = '0;
  logic [15:0] cmd_count_in = '0;
  logic [4:0]  cmd_stepsize_in = '0;
  logic [15:0] cmd_interval_in = '0;
  logic        abort_in = 1'b0;
  logic [9:0]  sel_out;
  logic        pulse_out;
  logic [4:0]  stepsize_out;
  logic        busy_out;
  logic        done_out;
  logic        aborted_out;
  logic [15:0] pulses_issued_out;
  logic [1:0]  state_out;

  int errors = 0;
  int checks = 0;

  // Per-capture record; cycle 1 is the cycle after the accept edge.
  logic        pulse_hist  [0:127];
  logic [9:0]  sel_hist    [0:127];
  logic [4:0]  step_hist   [0:127];
  logic [15:0] issued_hist [0:127];
  int          rise [0:7];
  int          nrise, bad_width, done_cyc;
  logic [15:0] done_issued;
  logic        done_aborted, done_ready, sel_seen;

  txpippm_step_scheduler dut (
    .gtwiz_userclk_tx_usrclk_in (gtwiz_userclk_tx_usrclk_in),
    .reset_in                   (reset_in),
    .cmd_valid_in               (cmd_valid_in),
    .cmd_ready_out              (cmd_ready_out),
    .cmd_sel_in                 (cmd_sel_in),
    .cmd_count_in               (cmd_count_in),
    .cmd_stepsize_in            (cmd_stepsize_in),
    .cmd_interval_in            (cmd_interval_in),
    .abort_in                   (abort_in),
    .sel_out                    (sel_out),
    .pulse_out                  (pulse_out),
    .stepsize_out               (stepsize_out),
    .busy_out                   (busy_out),
    .done_out                   (done_out),
    .aborted_out                (aborted_out),
    .pulses_issued_out          (pulses_issued_out),
    .state_out                  (state_out)
  );

  initial forever #5 gtwiz_userclk_tx_usrclk_in = ~gtwiz_userclk_tx_usrclk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a command on a falling edge; it is accepted on the next rising edge.
  task automatic issue(input logic [9:0] sel, input logic [15:0] cnt, input logic [4:0] step,
                       input logic [15:0] intv, input bit hold);
    @(negedge gtwiz_userclk_tx_usrclk_in);
    cmd_sel_in      = sel;
    cmd_count_in    = cnt;
    cmd_stepsize_in = step;
    cmd_interval_in = intv;
    cmd_valid_in    = 1'b1;
    @(posedge gtwiz_userclk_tx_usrclk_in);
    #1;
    if (!hold) cmd_valid_in = 1'b0;
  endtask

  // Sample each cycle until done_out is seen or the budget runs out.
  // abort_in is raised for the single cycle abort_cyc.
  task automatic capture(input int max_cyc, input int abort_cyc);
    int run;
    done_cyc = -1; done_issued = '0; done_aborted = 1'b0; done_ready = 1'b1; sel_seen = 1'b0;
    for (int c = 0; c < 128; c++) pulse_hist[c] = 1'b0;
    for (int c = 1; c <= max_cyc && done_cyc < 0; c++) begin
      @(negedge gtwiz_userclk_tx_usrclk_in);
      pulse_hist[c]  = pulse_out;
      sel_hist[c]    = sel_out;
      step_hist[c]   = stepsize_out;
      issued_hist[c] = pulses_issued_out;
      if (sel_out != '0) sel_seen = 1'b1;
      if (done_out) begin
        done_cyc     = c;
        done_issued  = pulses_issued_out;
        done_aborted = aborted_out;
        done_ready   = cmd_ready_out;
      end
      abort_in = (c == abort_cyc);
    end
    abort_in = 1'b0;
    nrise = 0; bad_width = 0; run = 0;
    for (int c = 1; c <= ((done_cyc > 0) ? done_cyc : max_cyc); c++) begin
      if (pulse_hist[c]) begin
        if (run == 0) begin
          if (nrise < 8) rise[nrise] = c;
          nrise++;
        end
        run++;
      end else begin
        if (run != 0 && run != 4) bad_width++;
        run = 0;
      end
    end
    if (run != 0) bad_width++;
  endtask

  initial begin
    // Reset state.
    repeat (2) @(posedge gtwiz_userclk_tx_usrclk_in);
    @(negedge gtwiz_userclk_tx_usrclk_in);
    check("rst_ready", cmd_ready_out, 0);
    check("rst_state", state_out, 0);
    check("rst_pulse", pulse_out, 0);
    check("rst_sel", sel_out, 0);
    check("rst_busy", busy_out, 0);
    check("rst_done", done_out, 0);
    check("rst_issued", pulses_issued_out, 0);
    reset_in = 1'b0;
    @(negedge gtwiz_userclk_tx_usrclk_in);
    check("rst_ready_after", cmd_ready_out, 1);

    // 1: three pulses at interval 10.
    issue(10'h005, 16'd3, 5'h03, 16'd10, 1'b0);
    capture(60, -1);
    check("t1_nrise", nrise, 3);
    check("t1_rise0", rise[0], 1);
    check("t1_rise1", rise[1], 11);
    check("t1_rise2", rise[2], 21);
    check("t1_width", bad_width, 0);
    check("t1_done_cyc", done_cyc, 31);
    check("t1_issued", done_issued, 3);
    check("t1_aborted", done_aborted, 0);
    check("t1_ready_in_done", done_ready, 0);
    check("t1_sel", sel_hist[1], 10'h005);
    check("t1_sel_done", sel_hist[31], 10'h005);
    check("t1_step", step_hist[1], 5'h03);
    check("t1_issued_c4", issued_hist[4], 0);
    check("t1_issued_c5", issued_hist[5], 1);
    check("t1_issued_c15", issued_hist[15], 2);
    @(negedge gtwiz_userclk_tx_usrclk_in);
    check("t1_ready_c32", cmd_ready_out, 1);
    check("t1_state_c32", state_out, 0);
    check("t1_sel_idle", sel_out, 0);
    check("t1_step_hold", stepsize_out, 5'h03);
    check("t1_issued_hold", pulses_issued_out, 3);

    // 2: interval below the minimum is clamped to 8.
    issue(10'h001, 16'd2, 5'h11, 16'd2, 1'b0);
    capture(60, -1);
    check("t2_nrise", nrise, 2);
    check("t2_rise0", rise[0], 1);
    check("t2_rise1", rise[1], 9);
    check("t2_width", bad_width, 0);
    check("t2_done_cyc", done_cyc, 17);

    // 3: zero-length command.
    issue(10'h3ff, 16'd0, 5'h07, 16'd10, 1'b0);
    capture(10, -1);
    check("t3_done_cyc", done_cyc, 1);
    check("t3_nrise", nrise, 0);
    check("t3_sel_seen", sel_seen, 0);
    check("t3_issued", done_issued, 0);
    check("t3_aborted", done_aborted, 0);

    // 4: abort during pulse 1; the high phase still runs its full length.
    issue(10'h0a0, 16'd5, 5'h02, 16'd20, 1'b0);
    capture(80, 22);
    check("t4_nrise", nrise, 2);
    check("t4_width", bad_width, 0);
    check("t4_done_cyc", done_cyc, 29);
    check("t4_aborted", done_aborted, 1);
    check("t4_issued", done_issued, 2);

    // abort_in in the accept cycle is ignored.
    abort_in = 1'b1;
    issue(10'h002, 16'd1, 5'h01, 16'd8, 1'b0);
    capture(30, -1);
    check("t4b_done_cyc", done_cyc, 9);
    check("t4b_aborted", done_aborted, 0);
    check("t4b_issued", done_issued, 1);

    // 5: valid held while busy; fields change but must not be re-latched.
    issue(10'h001, 16'd1, 5'h02, 16'd8, 1'b1);
    cmd_sel_in      = 10'h3ff;
    cmd_count_in    = 16'd2;
    cmd_stepsize_in = 5'h1f;
    capture(30, -1);
    check("t5_sel_hold", sel_hist[3], 10'h001);
    check("t5_step_hold", step_hist[3], 5'h02);
    check("t5_done_cyc", done_cyc, 9);
    check("t5_ready_in_done", done_ready, 0);
    @(negedge gtwiz_userclk_tx_usrclk_in);
    check("t5_ready_c10", cmd_ready_out, 1);
    @(negedge gtwiz_userclk_tx_usrclk_in);
    cmd_valid_in = 1'b0;
    check("t5_b_pulse", pulse_out, 1);
    check("t5_b_sel", sel_out, 10'h3ff);
    check("t5_b_step", stepsize_out, 5'h1f);
    // The second command was accepted at the edge before this sample.
    // Its done_out therefore falls 16 cycles further on.
    capture(40, -1);
    check("t5_b_done_cyc", done_cyc, 16);
    check("t5_b_issued", done_issued, 2);

    // 6: reset in the middle of a high phase.
    issue(10'h0f0, 16'd4, 5'h04, 16'd8, 1'b0);
    @(negedge gtwiz_userclk_tx_usrclk_in);
    check("t6_pulse_c1", pulse_out, 1);
    @(negedge gtwiz_userclk_tx_usrclk_in);
    reset_in = 1'b1;
    @(negedge gtwiz_userclk_tx_usrclk_in);
    check("t6_pulse_rst", pulse_out, 0);
    check("t6_sel_rst", sel_out, 0);
    check("t6_busy_rst", busy_out, 0);
    check("t6_state_rst", state_out, 0);
    check("t6_ready_rst", cmd_ready_out, 0);
    check("t6_step_rst", stepsize_out, 0);
    reset_in = 1'b0;
    @(negedge gtwiz_userclk_tx_usrclk_in);
    check("t6_ready_after", cmd_ready_out, 1);
    issue(10'h0f0, 16'd4, 5'h04, 16'd8, 1'b0);
    capture(60, -1);
    check("t6_nrise", nrise, 4);
    check("t6_rise3", rise[3], 25);
    check("t6_width", bad_width, 0);
    check("t6_done_cyc", done_cyc, 33);
    check("t6_issued", done_issued, 4);
    check("t6_sel", sel_hist[2], 10'h0f0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_txpippm_step_scheduler

// File: doc/txpippm_step_scheduler.md
# txpippm_step_scheduler

Command-driven sequencer feeding the TX phase-interpolator PPM controllers. It accepts a command of N phase steps, a step size, a channel select and a pulse interval. It then emits N well-formed pulses at the programmed spacing on the `pulse`/`stepsize`/`sel` inputs of the PPM controller block. All pulses meet that block's edge-detect requirements: high ≥4 cycles, low ≥4 cycles. The block runs entirely in the TXUSRCLK domain, upstream of the PPM controllers and downstream of the frequency-offset control logic.

## Interface
- `CHANNEL_COUNT`, 10: number of transceiver channels.
- `COUNT_WIDTH`, 16: width of the step count and issued-pulse counter.
- `INTERVAL_WIDTH`, 16: width of the pulse interval in cycles; must be ≥4.
- `gtwiz_userclk_tx_usrclk_in` in 1: TXUSRCLK; the only clock.
- `reset_in` in 1: synchronous, active-high reset.
- `cmd_valid_in` in 1: command valid.
- `cmd_ready_out` out 1: command accepted on `cmd_valid_in && cmd_ready_out`.
- `cmd_sel_in` in CHANNEL_COUNT: channels to step.
- `cmd_count_in` in COUNT_WIDTH: number of pulses, 0..2^COUNT_WIDTH-1.
- `cmd_stepsize_in` in 5: PI step size; bit 4 is direction, bits 3:0 are magnitude; passed through unchanged.
- `cmd_interval_in` in INTERVAL_WIDTH: cycles from one pulse rising edge to the next.
- `abort_in` in 1: stop the sequence after the current pulse.
- `sel_out` out CHANNEL_COUNT: drives PPM controller `sel_in`.
- `pulse_out` out 1: drives PPM controller `pulse_in`.
- `stepsize_out` out 5: drives PPM controller `stepsize_in`.
- `busy_out` out 1: high in the HIGH and LOW states.
- `done_out` out 1: one-cycle strobe when a sequence ends.
- `aborted_out` out 1: valid with `done_out`; 1 if the sequence ended by abort.
- `pulses_issued_out` out COUNT_WIDTH: pulses completed in the current or last sequence.
- `state_out` out 2: debug view of the state.

## Operation
States, encoded as follows:
- IDLE = 00
- HIGH = 01
- LOW = 11
- DONE = 10

Shared resources:
- One INTERVAL_WIDTH timer, reset to 0 on entry to HIGH.
- One COUNT_WIDTH issued counter.

State behaviour:
- **IDLE:**
  - `cmd_ready_out` = 1.
  - On accept, latch sel, stepsize and count.
  - Latch the interval as `max(cmd_interval_in, 8)`.
  - Clear the issued counter and the abort flag.
  - If count = 0, go to DONE; otherwise go to HIGH.
  - `abort_in` is ignored in IDLE, including in the accept cycle.
- **HIGH:**
  - `pulse_out` = 1; the timer increments each cycle.
  - At timer = 3, go to LOW and increment the issued counter.
- **LOW:**
  - `pulse_out` = 0; the timer keeps incrementing.
  - If the abort flag is set and timer ≥ 7, go to DONE with `aborted_out` = 1.
  - Otherwise, at timer = interval−1:
    - if issued = count, go to DONE;
    - else go to HIGH with timer = 0.
- **DONE:** `done_out` = 1 for one cycle, then IDLE.

Abort:
- `abort_in` seen in HIGH or LOW sets a sticky abort flag.
- A pulse already in HIGH is never truncated.
- LOW always lasts ≥4 cycles, so downstream returns to its low state.

Output holding:
- `sel_out` holds the latched select in HIGH, LOW and DONE; it is 0 in IDLE.
- `stepsize_out` holds the last latched value until the next accept.
- `pulses_issued_out` holds until the next accept.

Reset:
- Reset overrides all activity, including mid-pulse.
- State goes to IDLE; every output and register goes to 0.
- `cmd_ready_out` is 0 while `reset_in` is high and 1 in the first cycle after.

## Timing
- All outputs except `cmd_ready_out` are registered. `cmd_ready_out` = (state == IDLE) && !`reset_in`.
- For an accept at edge k with count N ≥ 1 and effective interval I:
  - pulse n (0-based) is high in cycles k+1+n·I through k+4+n·I;
  - `done_out` is high in cycle k+1+N·I;
  - `cmd_ready_out` is high again in cycle k+2+N·I.
- Count = 0: `done_out` in cycle k+1 and no pulse.
- Abort sampled during pulse m: `done_out` in cycle k+1+m·I+8, unless the sequence's natural end is earlier; `pulses_issued_out` = m+1.
- `pulses_issued_out` increments in the cycle `pulse_out` falls.
- Simultaneous abort and natural end in LOW: the sequence ends at the earlier of the two conditions; `aborted_out` = 1 only if the abort path fired first.
- Downstream reaction: PPM enable asserts 2 cycles per pulse, beginning one cycle after the pulse rises plus the synchronizer latency.

## Structure
- Package `txpippm_pkg` holds:
  - state localparams;
  - `PULSE_HIGH_CYCLES` = 4 and `MIN_INTERVAL` = 8;
  - the stepsize direction bit index.
- Optional sub-module `txpippm_interval_timer`: a loadable up-counter with terminal-compare outputs (≥3, ≥7, = interval−1).
- The FSM and counters remain in the top module.

## Test plan
1. sel=10'h005, count=3, interval=10, stepsize=5'h03 → 3 pulses of 4 cycles rising at k+1, k+11 and k+21; `done_out` at k+31; `pulses_issued_out`=3; `aborted_out`=0.
2. interval=2, count=2 → interval clamped to 8; rising edges at k+1 and k+9; `done_out` at k+17.
3. count=0 → `done_out` at k+1; `pulse_out` never high; `sel_out` never non-zero.
4. count=5, interval=20, `abort_in` pulsed mid-way through pulse index 1 → pulse completes its 4 high cycles; `done_out` at k+29 with `aborted_out`=1; issued=2.
5. `cmd_valid_in` held high while busy → no re-latch; a second command is accepted the cycle after DONE.
6. `reset_in` asserted mid-HIGH:
   - `pulse_out`, `sel_out` and `busy_out` are 0 the next cycle;
   - state = 00;
   - a new command runs normally after reset.
   Also, with the PPM controller block attached and count=4, interval=8 → exactly 4 enable bursts of 2 cycles on the selected channels.
